mcenoc_rx_assembler: RTL
========================

MCENOC_RX_ASSEMBLER -- requirements
Module: mcenoc_rx_assembler

Interface
REQ-001 Parameter DWIDTH, default 8; link flit width; SHALL be one of 1, 2, 4, 8, 16 or 32.
REQ-002 Parameter FIFO_DEPTH, default 4; output word FIFO entries; SHALL be a power of two and at least 2.
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 data_in  in  DWIDTH  flit from network port output.
REQ-006 act_in  in  1  flit valid.
REQ-007 clm_in  in  1  port claimed; high for the duration of a packet.
REQ-008 cts_out  out  1  clear-to-send back to network.
REQ-009 word_data  out  32  assembled word at FIFO head.
REQ-010 word_last  out  1  head word is final word of its packet.
REQ-011 word_valid  out  1  FIFO non-empty.
REQ-012 word_ready  in  1  consumer (NI) accepts head word.
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 proto_err  out  1  sticky protocol-error flag.
REQ-015 err_clr  in  1  clears proto_err.

Function
REQ-016 Flit accept SHALL occur in a cycle where act_in && cts_out && state==PKT.
REQ-017 Beats per word SHALL be BPW = 32/DWIDTH; flit k (0-based) of a word SHALL land in bits [k*DWIDTH +: DWIDTH] (little-endian).
REQ-018 States: IDLE, PKT, CLOSE; IDLE->PKT when clm_in high; PKT->CLOSE when clm_in low; CLOSE->IDLE when all pending pushes are done.
REQ-019 A completed word SHALL be held one deep in a hold register; when a later word completes, the held word SHALL be pushed with last=0 and the new word SHALL take its place.
REQ-020 CLOSE with held word and zero partial flits: push held word with last=1 (one cycle).
REQ-021 CLOSE with held word and partial flits: push held word with last=0, then push the zero-padded partial word with last=1 the next cycle.
REQ-022 CLOSE with no held word and partial flits: push the zero-padded partial word with last=1.
REQ-023 CLOSE with no held word and no partial flits (empty packet): push nothing and return to IDLE next cycle.
REQ-024 In CLOSE, a required push SHALL stall while the FIFO is full; state SHALL persist until every push completes.
REQ-025 cts_out SHALL be high only when state==PKT and fifo_count < FIFO_DEPTH-1, reserving one entry for the held word; it SHALL be low in IDLE and CLOSE.
REQ-026 FIFO pop SHALL occur when word_valid && word_ready; a simultaneous push and pop SHALL leave fifo_count unchanged; a push into a full FIFO SHALL never occur.
REQ-027 FIFO output SHALL be registered; a word pushed at edge N SHALL be visible on word_valid/word_data after edge N.
REQ-028 act_in high while state!=PKT SHALL set proto_err; the flit SHALL be discarded.
REQ-029 err_clr SHALL clear proto_err; a same-cycle set SHALL take priority.
REQ-030 clm_in rising again while in CLOSE SHALL be ignored until IDLE is reached.

Reset
REQ-031 While resetn is low, outputs SHALL be: cts_out=0, word_valid=0, word_last=0, word_data=0, fifo_count=0, proto_err=0; state SHALL be IDLE, with hold and partial registers empty.
REQ-032 Reset asserted mid-packet SHALL discard all held, partial and FIFO data; after deassertion the block SHALL wait in IDLE for a fresh clm_in rise.

Verification (DWIDTH=8, FIFO_DEPTH=4)
REQ-033 Claim, send 8 flits 0x01..0x08, release, word_ready=1 -> words 0x04030201 (last=0), then 0x08070605 (last=1).
REQ-034 Claim, send 6 flits 0xA1..0xA6, release -> 0xA4A3A2A1 (last=0), then 0x0000A6A5 (last=1) pushed in consecutive cycles.
REQ-035 Claim then release with no flits -> no words; state back to IDLE in 2 cycles; proto_err=0.
REQ-036 word_ready=0, stream 20 flits -> cts_out drops once fifo_count=3; no flit lost; after draining, every word matches in order.
REQ-037 act_in=1 with clm_in=0 -> proto_err=1 next cycle, FIFO unchanged; err_clr pulse -> proto_err=0.
REQ-038 resetn low after 5 flits of a packet -> all outputs 0; the next packet's first word contains only new flits.

Source files
------------

// File: rtl/mcenoc_rx_assembler.sv
// Receive-side assembler: packs DWIDTH-bit network flits into 32-bit words and
// queues them, with packet-end marking, for the network interface.
module mcenoc_rx_assembler #(
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [DWIDTH-1:0]               data_in,
    input  logic                            act_in,
    input  logic                            clm_in,
    output logic                            cts_out,
    output logic [31:0]                     word_data,
    output logic                            word_last,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            proto_err,
    input  logic                            err_clr
);
    localparam int BPW  = 32 / DWIDTH;
    localparam int CW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1, CLOSE = 2'd2} state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [31:0]       part_r, part_s;
    logic [31:0]       hold_r, hold_s;
    logic              hold_vld_r, hold_vld_s;
    logic              push_s, push_last_s, pop_s, full_s, accept_s, word_done_s;
    logic [31:0]       push_data_s, flit_ext_s, merged_s;
    logic [31:0]       mem_r [FIFO_DEPTH];
    logic              last_mem_r [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNTW-1:0]   count_r, count_s;
    logic              cts_r, valid_r, err_r;

    assign flit_ext_s  = 32'(data_in);
    assign merged_s    = part_r | (flit_ext_s << (int'(cnt_r) * DWIDTH));
    assign accept_s    = act_in && cts_r && (state_r == PKT);
    assign word_done_s = accept_s && (cnt_r == CW'(BPW - 1));
    assign full_s      = (count_r == CNTW'(FIFO_DEPTH));
    assign pop_s       = valid_r && word_ready;

    // Packet state machine: flit packing, hold register and end-of-packet flush
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        part_s      = part_r;
        hold_s      = hold_r;
        hold_vld_s  = hold_vld_r;
        push_s      = 1'b0;
        push_data_s = hold_r;
        push_last_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clm_in) state_s = PKT;
                else        state_s = IDLE;
            end
            PKT: begin
                if (word_done_s) begin
                    cnt_s      = '0;
                    part_s     = 32'd0;
                    hold_s     = merged_s;
                    hold_vld_s = 1'b1;
                    push_s     = hold_vld_r;
                end else if (accept_s) begin
                    cnt_s  = cnt_r + CW'(1);
                    part_s = merged_s;
                end else begin
                    cnt_s  = cnt_r;
                end
                if (!clm_in) state_s = CLOSE;
                else         state_s = PKT;
            end
            CLOSE: begin
                // The held word always leaves first; the padded partial word follows it.
                if (full_s) begin
                    state_s = CLOSE;
                end else if (hold_vld_r) begin
                    push_s      = 1'b1;
                    push_last_s = (cnt_r == '0);
                    hold_vld_s  = 1'b0;
                    hold_s      = 32'd0;
                    if (cnt_r == '0) state_s = IDLE;
                    else             state_s = CLOSE;
                end else if (cnt_r != '0) begin
                    push_s      = 1'b1;
                    push_data_s = part_r;
                    push_last_s = 1'b1;
                    cnt_s       = '0;
                    part_s      = 32'd0;
                    state_s     = IDLE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next FIFO occupancy
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNTW'(1);
            2'b01:   count_s = count_r - CNTW'(1);
            default: count_s = count_r;
        endcase
    end

    // Assembler state, hold/partial registers and registered status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            part_r     <= 32'd0;
            hold_r     <= 32'd0;
            hold_vld_r <= 1'b0;
            count_r    <= '0;
            cts_r      <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            part_r     <= part_s;
            hold_r     <= hold_s;
            hold_vld_r <= hold_vld_s;
            count_r    <= count_s;
            // One entry stays free so the held word can always be flushed.
            cts_r      <= (state_s == PKT) && (count_s < CNTW'(FIFO_DEPTH - 1));
            valid_r    <= (count_s != '0);
            if (act_in && (state_r != PKT)) err_r <= 1'b1;
            else if (err_clr)               err_r <= 1'b0;
            else                            err_r <= err_r;
        end
    end

    // Word FIFO storage and pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i]      <= 32'd0;
                last_mem_r[i] <= 1'b0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r]      <= push_data_s;
                last_mem_r[wr_ptr_r] <= push_last_s;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            else       rd_ptr_r <= rd_ptr_r;
        end
    end

    assign cts_out    = cts_r;
    assign word_valid = valid_r;
    assign word_data  = mem_r[rd_ptr_r];
    assign word_last  = last_mem_r[rd_ptr_r];
    assign fifo_count = count_r;
    assign proto_err  = err_r;
endmodule
